// File: rtl/mrf_rd_ctrl.sv
// mrf_rd_ctrl: burst read sequencer for an MRF RAM with latency-tracked return FIFO; MRF_RD_STATS_EN adds a stall_cycles counter
module mrf_rd_ctrl #(
    parameter int DW = 32,
    parameter int AW = 9,
    parameter int RD_LAT = 2,
    parameter int FIFO_DEPTH = RD_LAT + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_len,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
`ifdef MRF_RD_STATS_EN
    output logic [31:0]   stall_cycles,
`endif
    output logic          busy
);
    localparam int IW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 2);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [RD_LAT:0] pv_q, pv_d, pl_q, pl_d;
    logic [IW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW:0] mem_q [FIFO_DEPTH];
    logic [OW-1:0] occ;
    logic issue, push, pop;

    assign cmd_ready = state_q == IDLE && !rst;
    assign busy = state_q != IDLE;
    assign ram_rd_addr = rd_addr_q;
    assign push = pv_q[RD_LAT];
    assign out_valid = cnt_q != '0;
    assign pop = out_valid && out_ready;
    assign out_data = out_valid ? mem_q[rp_q][DW-1:0] : '0;
    assign out_last = out_valid && mem_q[rp_q][DW];

    // Stage 0 lines up with ram_rd_addr, so stage RD_LAT lines up with ram_rd_data.
    always_comb begin
        occ = OW'(cnt_q);
        for (int i = 0; i <= RD_LAT; i++) occ = occ + OW'(pv_q[i]);
    end

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        rem_d = rem_q;
        rd_addr_d = rd_addr_q;
        issue = state_q == ISSUE && occ < OW'(FIFO_DEPTH);
        if (cmd_ready && cmd_valid) begin
            addr_d = cmd_base;
            rem_d = cmd_len;
            state_d = cmd_len != '0 ? ISSUE : IDLE;
        end
        if (issue) begin
            rd_addr_d = addr_q;
            addr_d = addr_q + AW'(1);
            rem_d = rem_q - LW'(1);
            state_d = rem_q == LW'(1) ? DRAIN : ISSUE;
        end
        if (state_q == DRAIN && pop && out_last) state_d = IDLE;
        pv_d = {pv_q[RD_LAT-1:0], issue};
        pl_d = {pl_q[RD_LAT-1:0], issue && rem_q == LW'(1)};
        wp_d = push ? (wp_q == IW'(FIFO_DEPTH - 1) ? '0 : wp_q + IW'(1)) : wp_q;
        rp_d = pop ? (rp_q == IW'(FIFO_DEPTH - 1) ? '0 : rp_q + IW'(1)) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            rem_q <= '0;
            rd_addr_q <= '0;
            pv_q <= '0;
            pl_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            rem_q <= rem_d;
            rd_addr_q <= rd_addr_d;
            pv_q <= pv_d;
            pl_q <= pl_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) if (push) mem_q[wp_q] <= {pl_q[RD_LAT], ram_rd_data};

`ifdef MRF_RD_STATS_EN
    logic [31:0] stall_q, stall_d;
    always_comb stall_d = out_valid && !out_ready && stall_q != '1 ? stall_q + 32'd1 : stall_q;
    always_ff @(posedge clk) stall_q <= rst ? '0 : stall_d;
    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mrf_rd_ctrl.sv
// tb_mrf_rd_ctrl: scoreboard bench for mrf_rd_ctrl with a 2-cycle RAM model
module tb_mrf_rd_ctrl;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int RD_LAT = 2;
    localparam int FD = RD_LAT + 2;
    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, out_ready = 1'b1;
    logic [AW-1:0] cmd_base = '0, ram_rd_addr, ram_a_q, prev_addr = '0;
    logic [AW:0] cmd_len = '0;
    logic [DW-1:0] ram_rd_data, out_data;
    logic cmd_ready, out_valid, out_last, busy;
`ifdef MRF_RD_STATS_EN
    logic [31:0] stall_cycles;
`endif
    int n_pass = 0, n_tot = 0, n_pop = 0, n_iss = 0;
    logic [DW:0] sb[$];

    mrf_rd_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
`ifdef MRF_RD_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {16'hBEEF, 7'd0, a};
    endfunction

    always @(posedge clk) begin
        ram_a_q <= ram_rd_addr;
        ram_rd_data <= ram_word(ram_a_q);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin : mon
        logic [DW:0] e;
        if (ram_rd_addr != prev_addr) n_iss++;
        prev_addr = ram_rd_addr;
        if (out_valid && out_ready) begin
            n_pop++;
            if (sb.size() == 0) chk("out_valid_unexpected", {63'd0, out_valid}, 64'd0);
            else begin
                e = sb.pop_front();
                chk("out_data", out_data, e[DW-1:0]);
                chk("out_last", out_last, e[DW]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] base, input logic [AW:0] len);
        int t = 0;
        while (!cmd_ready && t < 2000) begin cyc(1); t++; end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        for (int i = 0; i < int'(len); i++) sb.push_back({i == int'(len) - 1, ram_word(AW'(int'(base) + i))});
        cmd_base = base;
        cmd_len = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int t = 0;
        while ((sb.size() != 0 || busy) && t < budget) begin cyc(1); t++; end
        chk(name, {63'd0, sb.size() != 0 || busy}, 64'd0);
    endtask

    initial begin : wd
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int p0;
        cyc(3);
        @(negedge clk);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_addr", ram_rd_addr, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        cyc(1);

        send(9'h010, 10'd4);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) chk("first_addr", ram_rd_addr, 64'h010);
            chk($sformatf("burst_valid_T+%0d", k), {63'd0, out_valid}, {63'd0, k >= 4 && k <= 7});
            if (k == 8) chk("burst_busy_end", {63'd0, busy}, 64'd0);
        end
        cyc(1);
        drain("burst_drain", 50);

        send(9'h1FE, 10'd4);
        drain("wrap_drain", 50);

        p0 = n_pop;
        send(9'h080, 10'd16);
        for (int i = 0; i < 400 && (sb.size() != 0 || busy); i++) begin
            out_ready = (i % 4) == 0;
            cyc(1);
            chk("outstanding_le_depth", {63'd0, (n_iss - n_pop) <= FD}, 64'd1);
        end
        out_ready = 1'b1;
        drain("bp_drain", 50);
        chk("bp_count", 64'(n_pop - p0), 64'd16);

        send(9'h123, 10'd0);
        @(negedge clk);
        chk("zero_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("zero_no_valid", {63'd0, out_valid}, 64'd0);
        end
        cyc(1);

        p0 = n_pop;
        send(9'h005, 10'd512);
        drain("full_drain", 3000);
        chk("full_count", 64'(n_pop - p0), 64'd512);
        chk("full_last_addr", ram_rd_addr, 64'h004);

        p0 = n_pop;
        send(9'h040, 10'd8);
        cyc(6);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        sb.delete();
        chk("rst_mid_pops", 64'(n_pop - p0), 64'd3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", {63'd0, out_valid}, 64'd0);
        end
        cyc(1);
        p0 = n_pop;
        send(9'h0A0, 10'd2);
        drain("post_rst_drain", 50);
        chk("post_rst_count", 64'(n_pop - p0), 64'd2);

`ifdef MRF_RD_STATS_EN
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        out_ready = 1'b0;
        send(9'h030, 10'd2);
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        chk("stats_valid_seen", {63'd0, out_valid}, 64'd1);
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        drain("stats_drain", 50);
        chk("stall_cycles", stall_cycles, 64'd10);
`endif

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
